// File: rtl/parallel_converter_1_to_n.sv
// rtl/parallel_converter_1_to_n.sv - collects N_LANES coded blocks into one wide word, slot 0 in the MSBs.
// Optional start-of-word alignment input enabled by macro PARALLEL_CONVERTER_1_TO_N_SOF_EN.
module parallel_converter_1_to_n #(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int N_LANES         = 20,
    parameter int NB_DATA_BUS     = LEN_CODED_BLOCK * N_LANES
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic [LEN_CODED_BLOCK-1:0] i_data,
`ifdef PARALLEL_CONVERTER_1_TO_N_SOF_EN
    input  logic                       i_sof,
    output logic                       o_misalign,
`endif
    output logic [NB_DATA_BUS-1:0]     o_data,
    output logic                       o_valid,
    output logic [$clog2(N_LANES)-1:0] o_slot
);

    localparam int SLOT_W = $clog2(N_LANES);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_LANES - 1);

    logic [NB_DATA_BUS-1:0] staging_q, staging_d;
    logic [NB_DATA_BUS-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [SLOT_W-1:0]      wr_slot;
    logic                   accept;
    logic                   sof_hit;
    logic                   misalign_d;

    assign accept = i_enable & i_valid;

`ifdef PARALLEL_CONVERTER_1_TO_N_SOF_EN
    logic misalign_q;
    assign sof_hit = accept & i_sof;
    assign o_misalign = misalign_q;
`else
    assign sof_hit = 1'b0;
`endif

    always_comb begin
        staging_d  = staging_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        slot_d     = slot_q;
        misalign_d = 1'b0;
        // A start-of-word marker forces the block into slot 0, abandoning any partial word.
        wr_slot    = sof_hit ? '0 : slot_q;

        if (accept) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (wr_slot == SLOT_W'(i)) begin
                    staging_d[NB_DATA_BUS-1-i*LEN_CODED_BLOCK -: LEN_CODED_BLOCK] = i_data;
                end
            end

            if (wr_slot == LAST_SLOT) begin
                data_d  = staging_d;
                valid_d = 1'b1;
                slot_d  = '0;
            end else begin
                slot_d  = wr_slot + SLOT_W'(1);
            end

            misalign_d = sof_hit & (slot_q != '0);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            staging_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            slot_q    <= '0;
        end else begin
            staging_q <= staging_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            slot_q    <= slot_d;
        end
    end

`ifdef PARALLEL_CONVERTER_1_TO_N_SOF_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    logic unused_misalign;
    assign unused_misalign = misalign_d;
`endif

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_slot  = slot_q;

endmodule
